// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus bounce-rejecting level qualifier for the four direction buttons.
// Each channel also emits a registered one-cycle pulse when its debounced level rises.
module btn_debounce #(
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned STABLE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_l_pin_i,
    input  logic       btn_r_pin_i,
    input  logic       btn_u_pin_i,
    input  logic       btn_d_pin_i,
    output logic       btn_l_o,
    output logic       btn_r_o,
    output logic       btn_u_o,
    output logic       btn_d_o,
    output logic [3:0] btn_press_o
);

    localparam logic [CNT_W-1:0] StableCnt = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdleLow,
        StCheckHigh,
        StIdleHigh,
        StCheckLow
    } state_e;

    logic [3:0] pin;
    logic [3:0] level;
    logic [3:0] press;

    assign pin = {btn_l_pin_i, btn_r_pin_i, btn_u_pin_i, btn_d_pin_i};

    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic             s1_q, s2_q;
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             out_q, out_d;
        logic             press_q, press_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                state_q <= StIdleLow;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                press_q <= 1'b0;
            end else begin
                s1_q    <= pin[i];
                s2_q    <= s1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                press_q <= press_d;
            end
        end

        // The counter holds how many consecutive s2 samples have shown the new level;
        // the level is accepted on the sample that would make it StableCnt.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            out_d   = out_q;
            press_d = 1'b0;
            unique case (state_q)
                StIdleLow: begin
                    if (s2_q) begin
                        if (StableCnt == CntOne) begin
                            state_d = StIdleHigh;
                            out_d   = 1'b1;
                            press_d = 1'b1;
                        end else begin
                            state_d = StCheckHigh;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StCheckHigh: begin
                    if (!s2_q) begin
                        state_d = StIdleLow;
                        cnt_d   = '0;
                    end else if (cnt_q == StableCnt - CntOne) begin
                        state_d = StIdleHigh;
                        cnt_d   = '0;
                        out_d   = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StIdleHigh: begin
                    if (!s2_q) begin
                        if (StableCnt == CntOne) begin
                            state_d = StIdleLow;
                            out_d   = 1'b0;
                        end else begin
                            state_d = StCheckLow;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StCheckLow: begin
                    if (s2_q) begin
                        state_d = StIdleHigh;
                        cnt_d   = '0;
                    end else if (cnt_q == StableCnt - CntOne) begin
                        state_d = StIdleLow;
                        cnt_d   = '0;
                        out_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    state_d = StIdleLow;
                    cnt_d   = '0;
                    out_d   = 1'b0;
                end
            endcase
        end

        assign level[i] = out_q;
        assign press[i] = press_q;
    end

    assign btn_l_o     = level[3];
    assign btn_r_o     = level[2];
    assign btn_u_o     = level[1];
    assign btn_d_o     = level[0];
    assign btn_press_o = press;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with STABLE_CYCLES=4, CNT_W=3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_btn_debounce;

    localparam int unsigned CNT_W         = 3;
    localparam int unsigned STABLE_CYCLES = 4;

    if (STABLE_CYCLES < 1 || 64'(STABLE_CYCLES) >= (64'd1 << CNT_W)) begin : g_cfg_err
        $fatal(1, "btn_debounce config error: STABLE_CYCLES out of range for CNT_W");
    end

    logic       clk;
    logic       rst_n;
    logic       pin_l, pin_r, pin_u, pin_d;
    logic       out_l, out_r, out_u, out_d;
    logic [3:0] press;

    int total = 0;
    int bad   = 0;

    btn_debounce #(
        .CNT_W         (CNT_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_l_pin_i (pin_l),
        .btn_r_pin_i (pin_r),
        .btn_u_pin_i (pin_u),
        .btn_d_pin_i (pin_d),
        .btn_l_o     (out_l),
        .btn_r_o     (out_r),
        .btn_u_o     (out_u),
        .btn_d_o     (out_d),
        .btn_press_o (press)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] levels();
        return {out_l, out_r, out_u, out_d};
    endfunction

    initial begin
        rst_n = 1'b1;
        {pin_l, pin_r, pin_u, pin_d} = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        check("reset_levels", levels(), 4'b0000);
        check("reset_press", press, 4'b0000);

        // Pins high during reset: nothing may leak out.
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("in_reset", {levels() | press}, 4'b0000);
        end

        // Release with all pins held: 6 edges to qualify.
        rst_n = 1'b1;
        tick(5);
        check("post_rst_e4_levels", levels(), 4'b0000);
        check("post_rst_e4_press", press, 4'b0000);
        tick(1);
        check("post_rst_e5_levels", levels(), 4'b1111);
        check("post_rst_e5_press", press, 4'b1111);
        tick(1);
        check("post_rst_press_gone", press, 4'b0000);

        // Release all: 4'b1111 -> 0 with no press pulse.
        {pin_l, pin_r, pin_u, pin_d} = 4'b0000;
        tick(5);
        check("rel_all_e4", levels(), 4'b1111);
        check("rel_all_e4_press", press, 4'b0000);
        tick(1);
        check("rel_all_e5", levels(), 4'b0000);
        check("rel_all_e5_press", press, 4'b0000);
        tick(2);

        // Clean press of L.
        pin_l = 1'b1;
        tick(5);
        check("l_e4_levels", levels(), 4'b0000);
        tick(1);
        check("l_e5_levels", levels(), 4'b1000);
        check("l_e5_press", press, 4'b1000);
        tick(1);
        check("l_held_press", press, 4'b0000);
        tick(3);
        check("l_held_levels", levels(), 4'b1000);
        check("l_held_press2", press, 4'b0000);
        pin_l = 1'b0;
        tick(6);
        check("l_released", levels(), 4'b0000);

        // Bounce reject on U: high 3, low 1, high 3, low.
        pin_u = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 3) pin_u = 1'b0;
            if (k == 4) pin_u = 1'b1;
            if (k == 7) pin_u = 1'b0;
            tick(1);
            check("u_bounce", {out_u, press[1]}, 4'b0000);
        end

        // Qualify D, then release with bounce.
        pin_d = 1'b1;
        tick(6);
        check("d_press_levels", levels(), 4'b0001);
        check("d_press_pulse", press, 4'b0001);
        tick(1);
        pin_d = 1'b0;
        tick(2);
        pin_d = 1'b1;
        tick(1);
        pin_d = 1'b0;
        tick(1);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("d_rel_hold", {out_d, press}, {1'b1, 4'b0000});
        end
        tick(1);
        check("d_rel_fell", {out_d, press}, 5'b0_0000);
        tick(2);

        // R and D together, L two cycles later.
        pin_r = 1'b1;
        pin_d = 1'b1;
        tick(2);
        pin_l = 1'b1;
        tick(3);
        check("sim_e4", levels(), 4'b0000);
        tick(1);
        check("sim_rd_levels", levels(), 4'b0101);
        check("sim_rd_press", press, 4'b0101);
        tick(1);
        check("sim_gap_press", press, 4'b0000);
        tick(1);
        check("sim_l_levels", levels(), 4'b1101);
        check("sim_l_press", press, 4'b1000);
        tick(1);
        check("sim_after_press", press, 4'b0000);
        {pin_l, pin_r, pin_u, pin_d} = 4'b0000;
        tick(6);
        check("sim_released", levels(), 4'b0000);

        // Reset in the middle of the U check.
        pin_u = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_levels", levels(), 4'b0000);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("mid_rst_e4", levels(), 4'b0000);
        check("mid_rst_e4_press", press, 4'b0000);
        tick(1);
        check("mid_rst_e5", levels(), 4'b0010);
        check("mid_rst_e5_press", press, 4'b0010);
        tick(1);
        check("mid_rst_press_gone", press, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
